// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO of decoded key events with sticky overflow flag.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  ps2_event_t wr_data_i,
    input  logic       pop_i,
    output ps2_event_t rd_data_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       overflow_o
);

    localparam int AW = $clog2(DEPTH);

    ps2_event_t       mem_q [DEPTH];
    ps2_event_t       last_q;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             overflow_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot the simultaneous push lands in, so a full FIFO accepts both.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: the storage array has no reset; it is never observed until written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_i && !do_push) overflow_q <= 1'b1;
            if (!empty_o) last_q <= mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    assign rd_data_o  = empty_o ? last_q : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchroniser, clock glitch filter, frame FSM, prefix decode, event FIFO.
// Define PS2_REPEAT_FILTER_EN to suppress typematic auto-repeat make events.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    input  logic       rd_en,
    output logic [7:0] code,
    output logic       is_ext,
    output logic       is_break,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          filt_q;
    logic [FW-1:0] filt_cnt_q;
    logic          strobe_q;
    logic          data_s;

    ps2_state_t    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    byte_q;
    logic          byte_valid_q;
    logic          frame_err_q;

    logic          ext_q;
    logic          brk_q;
    logic          is_prefix;
    logic          event_v;
    logic          keep;
    logic          push;
    ps2_event_t    wr_event;
    ps2_event_t    head;

    assign data_s = data_sync_q[1];

    // Synchronisers reset to the idle-high bus level so reset never fakes a falling edge.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            strobe_q    <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_clk};
            data_sync_q <= {data_sync_q[0], PS2_data};
            strobe_q    <= 1'b0;
            if (clk_sync_q[1] == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_q     <= clk_sync_q[1];
                filt_cnt_q <= '0;
                strobe_q   <= ~clk_sync_q[1];
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (state_q == IDLE) begin
                tmo_q <= '0;
                if (strobe_q && !data_s) begin
                    state_q   <= DATA;
                    bit_cnt_q <= '0;
                end
            end else if (strobe_q) begin
                tmo_q <= '0;
                case (state_q)
                    DATA: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        parity_q <= data_s;
                        state_q  <= STOP;
                    end
                    default: begin
                        if (data_s && (^{shift_q, parity_q})) begin
                            byte_q       <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                endcase
            end else if (tmo_q == TMO_LAST) begin
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
                tmo_q       <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign is_prefix = (byte_q == PS2_PREFIX_EXT) || (byte_q == PS2_PREFIX_BRK);
    assign event_v   = byte_valid_q && !is_prefix;
    assign push      = event_v && keep;
    assign wr_event  = '{ext: ext_q, brk: brk_q, code: byte_q};

    always_ff @(posedge clk_100MHz) begin
        if (rst || frame_err_q) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_valid_q) begin
            if (byte_q == PS2_PREFIX_EXT) begin
                ext_q <= 1'b1;
            end else if (byte_q == PS2_PREFIX_BRK) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       rep_valid_q;
    logic [8:0] rep_q;
    logic       rep_match;

    assign rep_match = rep_valid_q && (rep_q == {ext_q, byte_q});
    assign keep      = brk_q || !rep_match;

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            rep_valid_q <= 1'b0;
            rep_q       <= '0;
        end else if (event_v) begin
            if (!brk_q) begin
                rep_valid_q <= 1'b1;
                rep_q       <= {ext_q, byte_q};
            end else if (rep_match) begin
                rep_valid_q <= 1'b0;
            end
        end
    end
`else
    assign keep = 1'b1;
`endif

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_100MHz),
        .rst_i      (rst),
        .push_i     (push),
        .wr_data_i  (wr_event),
        .pop_i      (rd_en),
        .rd_data_o  (head),
        .empty_o    (empty),
        .full_o     (full),
        .overflow_o (overflow)
    );

    assign code      = head.code;
    assign is_ext    = head.ext;
    assign is_break  = head.brk;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed self-checking bench for ps2_scancode_rx (PS/2 bit period shortened to keep runtime small).
module tb_ps2_scancode_rx;

    localparam int P       = 200;
    localparam int TIMEOUT = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] code;
    logic       is_ext;
    logic       is_break;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       frame_err;

    int vectors = 0;
    int fails   = 0;
    int err_hi  = 0;
    int err_ref;

    always #5 clk = ~clk;

    ps2_scancode_rx #(
        .FIFO_DEPTH    (8),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_100MHz(clk),
        .rst       (rst),
        .PS2_clk   (ps2_clk),
        .PS2_data  (ps2_data),
        .rd_en     (rd_en),
        .code      (code),
        .is_ext    (is_ext),
        .is_break  (is_break),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_hi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            wait_cyc(P / 4);
            ps2_data = bits[i];
            wait_cyc(P / 4);
            ps2_clk = 1'b0;
            wait_cyc(P / 2);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic frame(input logic [7:0] d);
        send_frame(d, 1'b0, 11);
        wait_cyc(20);
    endtask

    task automatic pop();
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [7:0] c, input logic e, input logic b);
        check({tag, "_empty"}, empty, 1'b0);
        check({tag, "_code"}, code, c);
        check({tag, "_ext"}, is_ext, e);
        check({tag, "_brk"}, is_break, b);
    endtask

    initial begin
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(2);
        check("rst_code", code, 8'h00);
        check("rst_ext", is_ext, 1'b0);
        check("rst_brk", is_break, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ferr", frame_err, 1'b0);

        // Single make code with exact push latency around the stop-bit falling edge.
        send_frame(8'h1C, 1'b0, 10);
        wait_cyc(P / 4);
        ps2_data = 1'b1;
        wait_cyc(P / 4);
        ps2_clk = 1'b0;
        repeat (11) @(posedge clk);
        #1 check("lat_early", empty, 1'b1);
        @(posedge clk);
        #1 check("lat_exact", empty, 1'b0);
        wait_cyc(P / 2);
        ps2_clk = 1'b1;
        wait_cyc(20);
        expect_head("f1c", 8'h1C, 1'b0, 1'b0);
        pop();
        check("f1c_popped", empty, 1'b1);
        check("f1c_hold", code, 8'h1C);

        // Extended break: prefixes fold into flags of one entry.
        frame(8'hE0);
        frame(8'hF0);
        check("pfx_none", empty, 1'b1);
        frame(8'h75);
        expect_head("e0f075", 8'h75, 1'b1, 1'b1);
        pop();
        check("e0f075_one", empty, 1'b1);
        frame(8'h1B);
        expect_head("flags_clr", 8'h1B, 1'b0, 1'b0);
        pop();

        // Parity error.
        err_ref = err_hi;
        send_frame(8'h1C, 1'b1, 11);
        wait_cyc(20);
        check("par_pulse", err_hi - err_ref, 1);
        check("par_empty", empty, 1'b1);

        // Fill past capacity.
        for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i));
        check("fill_full", full, 1'b1);
        check("fill_noovf", overflow, 1'b0);
        frame(8'h18);
        check("ovf_set", overflow, 1'b1);
        check("ovf_full", full, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), code, 8'h10 + 8'(i));
            pop();
        end
        check("drain_empty", empty, 1'b1);
        check("drain_notfull", full, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // Mid-frame stall: start + 4 data bits, then silence.
        err_ref = err_hi;
        send_frame(8'h29, 1'b0, 5);
        wait_cyc(TIMEOUT + 50);
        check("tmo_pulse", err_hi - err_ref, 1);
        check("tmo_empty", empty, 1'b1);
        frame(8'h29);
        expect_head("after_tmo", 8'h29, 1'b0, 1'b0);
        pop();
        check("after_tmo_one", empty, 1'b1);

        // Typematic repeat followed by release.
        frame(8'h1C);
        frame(8'h1C);
        frame(8'h1C);
        frame(8'hF0);
        frame(8'h1C);
        expect_head("rep0", 8'h1C, 1'b0, 1'b0);
        pop();
`ifndef PS2_REPEAT_FILTER_EN
        expect_head("rep1", 8'h1C, 1'b0, 1'b0);
        pop();
        expect_head("rep2", 8'h1C, 1'b0, 1'b0);
        pop();
`endif
        expect_head("rep_brk", 8'h1C, 1'b0, 1'b1);
        pop();
        check("rep_done", empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
